// File: rtl/dp_ram_arbiter.sv
// Four-requester arbiter for one single-port RAM: round-robin grant, a bounded
// hold time while others wait, and one-cycle-latency read data return.
module dp_ram_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [15:0]  req_addr,
  input  logic [3:0]   req_wr,
  input  logic [127:0] req_wdata,
  output logic [3:0]   gnt,
  output logic [3:0]   rvalid,
  output logic [31:0]  rdata,
  output logic [3:0]   ADDR,
  output logic         WRITE_F,
  output logic [31:0]  WRITE_DATA,
  input  logic [31:0]  READ_DATA,
  output logic [3:0]   BYTE_ENABLE,
  output logic [1:0]   owner_o,
  output logic [1:0]   state_o
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  // Handshake: req[i] is the requester's valid, gnt[i] its ready; a cycle is an
  // accepted access only when both are high, and only then does the RAM port move.
  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [3:0]    rvalid_q, rvalid_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          excl_vld_q, excl_vld_d;
  logic [1:0]    excl_idx_q, excl_idx_d;

  logic          owner_req;
  logic          access;
  logic          others_pend;
  logic [3:0]    cand;
  logic [1:0]    idx;
  logic [1:0]    winner;
  logic          found;

  always_comb begin
    owner_req   = req[owner_q];
    access      = (state_q == ST_GRANT) && owner_req;
    others_pend = |(req & ~(4'b0001 << owner_q));

    // A preempted owner sits out one arbitration, unless it is the only one asking.
    cand = req;
    if (excl_vld_q && |(req & ~(4'b0001 << excl_idx_q))) begin
      cand = req & ~(4'b0001 << excl_idx_q);
    end

    idx    = '0;
    winner = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && cand[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    excl_vld_d = excl_vld_q;
    excl_idx_d = excl_idx_q;
    rvalid_d   = (access && !req_wr[owner_q]) ? (4'b0001 << owner_q) : 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d    = ST_GRANT;
          owner_d    = winner;
          gnt_d      = 4'b0001 << winner;
          ptr_d      = winner + 2'd1;
          hold_d     = '0;
          excl_vld_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          owner_d = 2'd0;
          gnt_d   = 4'b0000;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST && others_pend) begin
          state_d    = ST_SWITCH;
          owner_d    = 2'd0;
          gnt_d      = 4'b0000;
          hold_d     = '0;
          excl_vld_d = 1'b1;
          excl_idx_d = owner_q;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_SWITCH: begin
        state_d = ST_IDLE;
        owner_d = 2'd0;
        gnt_d   = 4'b0000;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = 2'd0;
        gnt_d   = 4'b0000;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 2'd0;
      gnt_q      <= 4'b0000;
      rvalid_q   <= 4'b0000;
      ptr_q      <= 2'd0;
      hold_q     <= '0;
      excl_vld_q <= 1'b0;
      excl_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      excl_vld_q <= excl_vld_d;
      excl_idx_q <= excl_idx_d;
    end
  end

  always_comb begin
    ADDR       = 4'd0;
    WRITE_F    = 1'b0;
    WRITE_DATA = 32'd0;
    if (access) begin
      ADDR       = req_addr[{owner_q, 2'b00} +: 4];
      WRITE_F    = req_wr[owner_q];
      WRITE_DATA = req_wdata[{owner_q, 5'b00000} +: 32];
    end
  end

  assign gnt         = gnt_q;
  assign rvalid      = rvalid_q;
  assign rdata       = READ_DATA;
  assign BYTE_ENABLE = 4'b1111;
  assign owner_o     = owner_q;
  assign state_o     = state_q;

endmodule

// File: doc/dp_ram_arbiter.md
DP_RAM_ARBITER -- requirements
Module: dp_ram_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive granted cycles per owner while another requester is pending.
REQ-002 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req  in  4  per-requester access request, bit i = requester i.
REQ-005 req_addr  in  16  four packed 4-bit word addresses, requester i at [4i+3:4i].
REQ-006 req_wr  in  4  per-requester write strobe; 0 = read.
REQ-007 req_wdata  in  128  four packed 32-bit write words, requester i at [32i+31:32i].
REQ-008 gnt  out  4  one-hot grant, registered.
REQ-009 rvalid  out  4  one-hot read-data-valid pulse, registered.
REQ-010 rdata  out  32  read data, equal to READ_DATA.
REQ-011 ADDR  out  4  RAM port word address.
REQ-012 WRITE_F  out  1  RAM port write enable.
REQ-013 WRITE_DATA  out  32  RAM port write data.
REQ-014 READ_DATA  in  32  RAM port read data, valid one cycle after the address is presented.
REQ-015 BYTE_ENABLE  out  4  RAM port byte enables.
REQ-016 owner_o  out  2  index of the current owner; 0 when none.
REQ-017 state_o  out  2  current FSM state encoding.

Function
REQ-018 The FSM SHALL have states ST_IDLE=0, ST_GRANT=1, ST_SWITCH=2; encoding 3 SHALL return to ST_IDLE.
REQ-019 ST_IDLE with any req bit high SHALL select the winner by round-robin, starting at index ptr, and enter ST_GRANT next cycle with gnt[winner]=1.
REQ-020 ptr SHALL be set to (winner+1) mod 4 on every grant.
REQ-021 In ST_GRANT, ADDR, WRITE_F and WRITE_DATA SHALL be driven combinationally from the owner's req_addr, req_wr and req_wdata, qualified by req[owner].
REQ-022 Outside ST_GRANT, or when req[owner]=0, WRITE_F SHALL be 0, ADDR SHALL be 0 and WRITE_DATA SHALL be 0.
REQ-023 BYTE_ENABLE SHALL be constant 4'b1111.
REQ-024 ST_GRANT with req[owner]=0 SHALL go to ST_IDLE next cycle, dropping gnt; no access occurs in that cycle.
REQ-025 A hold counter SHALL be cleared on entering ST_GRANT and SHALL increment each ST_GRANT cycle, saturating at MAX_HOLD-1.
REQ-026 The FSM SHALL go ST_GRANT -> ST_SWITCH when all of the following hold:
- req[owner]=1
- hold counter = MAX_HOLD-1
- some other req bit is high
REQ-027 In the case of REQ-026, the last access SHALL still be performed in that cycle.
REQ-028 If no other requester is pending, the owner SHALL keep the grant indefinitely.
REQ-029 ST_SWITCH SHALL last one cycle with gnt=0 and the port idle, then return to ST_IDLE.
REQ-030 Following a forced release, ST_IDLE arbitration SHALL exclude the preempted requester for one arbitration.
REQ-031 rvalid[i] SHALL pulse for exactly one cycle following each ST_GRANT cycle in which owner=i, req[i]=1 and req_wr[i]=0.
REQ-032 rvalid SHALL never pulse after writes or idle cycles.
REQ-033 At most one gnt bit and at most one rvalid bit SHALL be high in any cycle.
REQ-034 A requester SHALL treat a cycle as accepted only when its gnt bit is high and its req bit is high.

Reset
REQ-035 rst=1 at a clock edge SHALL set the following on the next cycle, including mid-grant:
- state ST_IDLE
- gnt=0, rvalid=0
- owner_o=0, ptr=0, hold counter=0
- WRITE_F=0, ADDR=0, WRITE_DATA=0
REQ-036 A read in flight when reset is applied SHALL NOT produce an rvalid pulse.
REQ-037 Arbitration SHALL resume on the first cycle after rst=0, with requester 0 at highest priority.

Verification
REQ-038 Single write: req=0001, req_addr[3:0]=2, req_wr[0]=1, wdata=0x0000_00AB -> gnt=0001 next cycle; ADDR=2, WRITE_F=1, WRITE_DATA=0xAB in that cycle; rvalid stays 0.
REQ-039 Read: RAM word 3 = 0x0000_0015, requester 2 reads addr 3 -> rvalid=0100 one cycle after the granted cycle, with rdata=0x15.
REQ-040 Round-robin: req=1111 held, each grant one cycle then req dropped and reasserted -> grant order 0,1,2,3,0.
REQ-041 Hold limit: MAX_HOLD=4, req=0011 held continuously -> requester 0 granted 4 cycles, one ST_SWITCH cycle, one ST_IDLE cycle, then requester 1 granted 4 cycles.
REQ-042 Sole requester: req=1000 held 50 cycles -> gnt=1000 continuously after the first grant, with no ST_SWITCH.
REQ-043 Reset mid-read: rst=1 in the cycle a read is presented -> next cycle gnt=0, rvalid=0, state_o=0, ADDR=0.
